// File: rtl/snitch_icache_pkg.sv
// Shared types and helpers for the icache request arbiter.
// Holds the port-slice arithmetic and the derived cache ID width.
package snitch_icache_pkg;

    typedef enum logic {
        ArbFree,
        ArbLocked
    } arb_state_e;

    function automatic int unsigned id_width(
        input int unsigned ports,
        input int unsigned port_w
    );
        return ports * port_w;
    endfunction

    function automatic int unsigned slice_lo(
        input int unsigned port,
        input int unsigned w
    );
        return port * w;
    endfunction

endpackage

// File: rtl/snitch_icache_req_arbiter_rr.sv
// Round-robin arbiter whose grant is held from a stalled request
// until it handshakes, so the winner's addr/id stay stable.
module snitch_icache_req_arbiter_rr
    import snitch_icache_pkg::*;
#(
    parameter int unsigned NumPorts = 2,
    parameter int unsigned IdxW     = $clog2(NumPorts)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [NumPorts-1:0] req_i,
    input  logic                ready_i,
    output logic [IdxW-1:0]     idx_o,
    output logic                valid_o
);

    arb_state_e      state_q, state_d;
    logic [IdxW-1:0] ptr_q, ptr_d;
    logic [IdxW-1:0] lock_idx_q, lock_idx_d;
    logic [IdxW-1:0] pick;
    logic            found;

    // Scan a doubled index range so the search wraps from ptr_q.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < 2 * NumPorts; i++) begin
            if (!found && req_i[i % NumPorts] &&
                i >= 32'(ptr_q) && i < 32'(ptr_q) + NumPorts) begin
                found = 1'b1;
                pick  = IdxW'(i % NumPorts);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        lock_idx_d = lock_idx_q;
        valid_o    = |req_i;
        idx_o      = pick;
        unique case (state_q)
            ArbFree: begin
                if (valid_o && !ready_i) begin
                    state_d    = ArbLocked;
                    lock_idx_d = pick;
                end
            end
            ArbLocked: begin
                idx_o = lock_idx_q;
            end
            default: state_d = ArbFree;
        endcase
        if (valid_o && ready_i) begin
            state_d = ArbFree;
            if (32'(idx_o) == NumPorts - 1) begin
                ptr_d = '0;
            end else begin
                ptr_d = idx_o + IdxW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ArbFree;
            ptr_q      <= '0;
            lock_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            lock_idx_q <= lock_idx_d;
        end
    end

    a_hold_while_locked : assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        (state_q == ArbLocked) |-> req_i[lock_idx_q]
    );

endmodule

// File: rtl/snitch_icache_req_arbiter.sv
// Shares one icache lookup port among NumPorts fetch front-ends and
// forks each cache response to every port named in its ID vector.
module snitch_icache_req_arbiter
    import snitch_icache_pkg::*;
#(
    parameter int unsigned NumPorts    = 2,
    parameter int unsigned PortIdWidth = 4,
    parameter int unsigned FetchAw     = 32,
    parameter int unsigned LineWidth   = 128,
    parameter int unsigned IdWidth     = id_width(NumPorts, PortIdWidth)
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic [NumPorts*FetchAw-1:0]     in_addr_i,
    input  logic [NumPorts*PortIdWidth-1:0] in_id_i,
    input  logic [NumPorts-1:0]             in_valid_i,
    output logic [NumPorts-1:0]             in_ready_o,
    output logic [LineWidth-1:0]            in_rsp_data_o,
    output logic                            in_rsp_error_o,
    output logic [NumPorts*PortIdWidth-1:0] in_rsp_id_o,
    output logic [NumPorts-1:0]             in_rsp_valid_o,
    input  logic [NumPorts-1:0]             in_rsp_ready_i,
    output logic [FetchAw-1:0]              out_addr_o,
    output logic [IdWidth-1:0]              out_id_o,
    output logic                            out_valid_o,
    input  logic                            out_ready_i,
    input  logic [LineWidth-1:0]            out_rsp_data_i,
    input  logic                            out_rsp_error_i,
    input  logic [IdWidth-1:0]              out_rsp_id_i,
    input  logic                            out_rsp_valid_i,
    output logic                            out_rsp_ready_o
);

    localparam int unsigned IdxW = $clog2(NumPorts);

    logic [IdxW-1:0]     win;
    logic                win_valid;
    logic [NumPorts-1:0] need, done;
    logic [NumPorts-1:0] sent_q, sent_d;

    snitch_icache_req_arbiter_rr #(
        .NumPorts (NumPorts),
        .IdxW     (IdxW)
    ) i_rr (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .req_i   (in_valid_i),
        .ready_i (out_ready_i),
        .idx_o   (win),
        .valid_o (win_valid)
    );

    always_comb begin
        out_valid_o = win_valid;
        out_addr_o  = '0;
        out_id_o    = '0;
        in_ready_o  = '0;
        for (int unsigned p = 0; p < NumPorts; p++) begin
            if (win == IdxW'(p)) begin
                out_addr_o = in_addr_i[slice_lo(p, FetchAw) +: FetchAw];
                out_id_o[slice_lo(p, PortIdWidth) +: PortIdWidth] =
                    in_id_i[slice_lo(p, PortIdWidth) +: PortIdWidth];
                in_ready_o[p] = win_valid & out_ready_i;
            end
        end
    end

    // Ports that do not need the response never hold up the fork.
    always_comb begin
        need = '0;
        for (int unsigned p = 0; p < NumPorts; p++) begin
            need[p] = |out_rsp_id_i[slice_lo(p, PortIdWidth) +: PortIdWidth];
        end
        in_rsp_id_o     = out_rsp_id_i;
        in_rsp_data_o   = out_rsp_data_i;
        in_rsp_error_o  = out_rsp_error_i;
        in_rsp_valid_o  = {NumPorts{out_rsp_valid_i}} & need & ~sent_q;
        done            = ~need | sent_q | in_rsp_ready_i;
        out_rsp_ready_o = out_rsp_valid_i & (&done);
        if (out_rsp_ready_o) begin
            sent_d = '0;
        end else begin
            sent_d = sent_q | (in_rsp_valid_o & in_rsp_ready_i);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sent_q <= '0;
        end else begin
            sent_q <= sent_d;
        end
    end

    c_empty_rsp_id : cover property (
        @(posedge clk_i) disable iff (!rst_ni)
        out_rsp_valid_i && !(|out_rsp_id_i)
    );

endmodule

// File: tb/tb_snitch_icache_req_arbiter.sv
// Randomized scoreboard bench for the icache request arbiter.
module tb_snitch_icache_req_arbiter;

    localparam int NP   = 2;
    localparam int PIW  = 4;
    localparam int AW   = 32;
    localparam int LW   = 128;
    localparam int IW   = NP * PIW;
    localparam int NCYC = 1500;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NP*AW-1:0]  in_addr;
    logic [NP*PIW-1:0] in_id;
    logic [NP-1:0]     in_valid, in_ready;
    logic [LW-1:0]     rsp_data;
    logic              rsp_err;
    logic [NP*PIW-1:0] rsp_id;
    logic [NP-1:0]     rsp_valid, rsp_ready;
    logic [AW-1:0]     out_addr;
    logic [IW-1:0]     out_id;
    logic              out_valid, out_ready;
    logic [LW-1:0]     c_data;
    logic              c_err;
    logic [IW-1:0]     c_id;
    logic              c_valid, c_rready;

    always #5 clk = ~clk;

    snitch_icache_req_arbiter #(
        .NumPorts    (NP),
        .PortIdWidth (PIW),
        .FetchAw     (AW),
        .LineWidth   (LW)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .in_addr_i       (in_addr),
        .in_id_i         (in_id),
        .in_valid_i      (in_valid),
        .in_ready_o      (in_ready),
        .in_rsp_data_o   (rsp_data),
        .in_rsp_error_o  (rsp_err),
        .in_rsp_id_o     (rsp_id),
        .in_rsp_valid_o  (rsp_valid),
        .in_rsp_ready_i  (rsp_ready),
        .out_addr_o      (out_addr),
        .out_id_o        (out_id),
        .out_valid_o     (out_valid),
        .out_ready_i     (out_ready),
        .out_rsp_data_i  (c_data),
        .out_rsp_error_i (c_err),
        .out_rsp_id_i    (c_id),
        .out_rsp_valid_i (c_valid),
        .out_rsp_ready_o (c_rready)
    );

    typedef struct packed {
        logic          ov;
        logic [AW-1:0] addr;
        logic [IW-1:0] oid;
        logic [NP-1:0] irdy;
        logic [NP-1:0] rv;
        logic [IW-1:0] rid;
        logic          ordy;
        logic [LW-1:0] data;
        logic          err;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    bit   done   = 1'b0;

    task automatic chk(input string name, input logic [LW-1:0] act,
                       input logic [LW-1:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, req, $time);
        end
    endtask

    // Monitor: one expected record per cycle, compared mid-cycle.
    initial begin
        exp_t e;
        while (!done) begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL sb_empty: got no expected record at %0t",
                         $time);
            end else begin
                e = exp_q.pop_front();
                chk("out_valid", LW'(out_valid), LW'(e.ov));
                if (e.ov) begin
                    chk("out_addr", LW'(out_addr), LW'(e.addr));
                    chk("out_id", LW'(out_id), LW'(e.oid));
                end
                chk("in_ready", LW'(in_ready), LW'(e.irdy));
                chk("rsp_valid", LW'(rsp_valid), LW'(e.rv));
                chk("rsp_id", LW'(rsp_id), LW'(e.rid));
                chk("rsp_ready", LW'(c_rready), LW'(e.ordy));
                chk("rsp_data", rsp_data, e.data);
                chk("rsp_err", LW'(rsp_err), LW'(e.err));
            end
        end
    end

    // Reference model state: per-port FIFOs, pointer, lock, fork progress.
    logic [AW-1:0]  qa[NP][$];
    logic [PIW-1:0] qi[NP][$];
    int             ptr, lock_w, w;
    bit             locked, any, found;
    bit             rsp_act;
    logic [IW-1:0]  r_id;
    logic [LW-1:0]  r_data;
    logic           r_err;
    logic [NP-1:0]  sent, need;
    bit             all_done;
    bit             p_hs, p_ov, p_rdone;
    int             p_w;
    logic [NP-1:0]  p_phs;

    initial begin
        exp_t e;
        rst_n     = 1'b0;
        in_addr   = '0;
        in_id     = '0;
        in_valid  = '0;
        out_ready = 1'b0;
        rsp_ready = '0;
        c_valid   = 1'b0;
        c_id      = '0;
        c_data    = '0;
        c_err     = 1'b0;
        ptr = 0; locked = 0; lock_w = 0;
        rsp_act = 0; sent = '0;
        r_id = '0; r_data = '0; r_err = 1'b0;
        p_hs = 0; p_ov = 0; p_w = 0; p_rdone = 0; p_phs = '0;
        for (int c = 0; c < NCYC; c++) begin
            @(posedge clk);
            #1;
            if (p_hs) begin
                void'(qa[p_w].pop_front());
                void'(qi[p_w].pop_front());
                ptr    = (p_w + 1) % NP;
                locked = 0;
            end else if (p_ov) begin
                locked = 1;
                lock_w = p_w;
            end
            if (p_rdone) begin
                sent    = '0;
                rsp_act = 0;
            end else begin
                sent = sent | p_phs;
            end
            rst_n = !(c < 3 || c == 400 || c == 900);
            if (!rst_n) begin
                ptr = 0; locked = 0; sent = '0; rsp_act = 0;
                for (int p = 0; p < NP; p++) begin
                    qa[p].delete();
                    qi[p].delete();
                end
            end else begin
                for (int p = 0; p < NP; p++) begin
                    if (qa[p].size() < 3 && $urandom_range(0, 2) == 0) begin
                        qa[p].push_back($urandom);
                        qi[p].push_back(PIW'(1) << $urandom_range(0, PIW - 1));
                    end
                end
                if (!rsp_act && (c == 397 || $urandom_range(0, 1) == 0)) begin
                    rsp_act = 1;
                    for (int p = 0; p < NP; p++) begin
                        if (c == 397 || $urandom_range(0, 2) != 0)
                            r_id[p*PIW +: PIW] = PIW'(1) << $urandom_range(0, PIW - 1);
                        else
                            r_id[p*PIW +: PIW] = '0;
                    end
                    r_data = {$urandom, $urandom, $urandom, $urandom};
                    r_err  = 1'($urandom_range(0, 1));
                end
            end
            for (int p = 0; p < NP; p++) begin
                in_valid[p] = rst_n && qa[p].size() > 0;
                in_addr[p*AW +: AW]  = in_valid[p] ? qa[p][0] : '0;
                in_id[p*PIW +: PIW]  = in_valid[p] ? qi[p][0] : '0;
            end
            out_ready = ($urandom_range(0, 3) != 0);
            rsp_ready = NP'($urandom_range(0, (1 << NP) - 1));
            if (c >= 397 && c < 400) rsp_ready = NP'(1);
            c_valid = rsp_act;
            c_id    = rsp_act ? r_id : '0;
            c_data  = r_data;
            c_err   = r_err;

            any   = |in_valid;
            w     = 0;
            found = 0;
            if (locked) begin
                w = lock_w;
            end else begin
                for (int k = 0; k < NP; k++) begin
                    if (!found && in_valid[(ptr + k) % NP]) begin
                        found = 1;
                        w     = (ptr + k) % NP;
                    end
                end
            end
            e      = '0;
            e.ov   = any;
            if (any) begin
                e.addr = qa[w][0];
                e.oid  = IW'(qi[w][0]) << (w * PIW);
            end
            e.irdy = (any && out_ready) ? NP'(1) << w : '0;
            all_done = 1;
            for (int p = 0; p < NP; p++) begin
                need[p] = (c_id[p*PIW +: PIW] != '0);
                if (need[p] && !sent[p] && !rsp_ready[p]) all_done = 0;
            end
            e.rv   = c_valid ? (need & ~sent) : '0;
            e.rid  = c_id;
            e.ordy = c_valid && all_done;
            e.data = c_data;
            e.err  = c_err;
            exp_q.push_back(e);

            p_hs    = any && out_ready;
            p_ov    = any;
            p_w     = w;
            p_rdone = e.ordy;
            p_phs   = e.rv & rsp_ready;
        end
        @(negedge clk);
        #1;
        done = 1'b1;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
